// File: rtl/seq_step_engine.sv
// Step sequencer: plays a NUM_STEPS pattern of {active, note} entries, one step per
// rising edge of the asynchronous tempo clock, with a fixed-length or legato gate.
module seq_step_engine #(
  parameter int NUM_STEPS  = 8,
  parameter int NOTE_W     = 4,
  parameter int GATE_TICKS = 10
) (
  input  logic                         clk100hz,
  input  logic                         reset,
  input  logic                         variableClk,
  input  logic                         run,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
  input  logic [NOTE_W-1:0]            wr_note,
  input  logic                         wr_active,
  output logic [NOTE_W-1:0]            note_out,
  output logic                         gate,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         step_pulse,
  output logic [1:0]                   state_dbg
);

  localparam int AW = $clog2(NUM_STEPS);
  localparam int CW = $clog2(GATE_TICKS + 1);

  typedef enum logic [1:0] {ST_STOP = 2'd0, ST_WAIT = 2'd1, ST_GATE = 2'd2} state_t;

  state_t              state;
  logic [AW-1:0]       ptr;
  logic [CW-1:0]       cnt;
  logic                sync1, sync2, sync3;
  logic                tick;
  logic [NUM_STEPS-1:0] act_mem;
  logic [NOTE_W-1:0]   note_mem [NUM_STEPS];

  assign state_dbg = state;

  // sync1/sync2 form the synchronizer; sync3 remembers the previous synced value
  always_ff @(posedge clk100hz or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= variableClk;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign tick = sync2 & ~sync3;

  // Nonblocking write means a same-edge play reads the old entry
  always_ff @(posedge clk100hz or posedge reset) begin
    if (reset) begin
      act_mem <= '0;
      for (int i = 0; i < NUM_STEPS; i++) note_mem[i] <= '0;
    end else if (wr_en) begin
      act_mem[wr_addr]  <= wr_active;
      note_mem[wr_addr] <= wr_note;
    end
  end

  always_ff @(posedge clk100hz or posedge reset) begin
    if (reset) begin
      state      <= ST_STOP;
      gate       <= 1'b0;
      step_pulse <= 1'b0;
      note_out   <= '0;
      step_idx   <= '0;
      ptr        <= '0;
      cnt        <= '0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        ST_STOP: begin
          gate <= 1'b0;
          ptr  <= '0;
          if (run) state <= ST_WAIT;
        end
        ST_WAIT, ST_GATE: begin
          if (!run) begin
            state <= ST_STOP;
            gate  <= 1'b0;
            ptr   <= '0;
          end else if (tick) begin
            step_idx   <= ptr;
            ptr        <= ptr + 1'b1;
            step_pulse <= 1'b1;
            if (act_mem[ptr]) begin
              note_out <= note_mem[ptr];
              gate     <= 1'b1;
              cnt      <= CW'(GATE_TICKS - 1);
              state    <= ST_GATE;
            end else begin
              gate  <= 1'b0;
              state <= ST_WAIT;
            end
          end else if (state == ST_GATE) begin
            if (cnt == '0) begin
              gate  <= 1'b0;
              state <= ST_WAIT;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= ST_STOP;
          gate  <= 1'b0;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_step_engine.sv
// Directed bench for seq_step_engine: a step-level reference model compared every
// cycle, plus hand-computed checks for sequencing, legato, stop, write and reset.
module tb_seq_step_engine;

  localparam int N  = 8;
  localparam int NW = 4;
  localparam int GT = 10;
  localparam int AW = $clog2(N);

  // clock / reset
  logic clk100hz = 1'b0;
  logic reset    = 1'b0;
  always #5 clk100hz = ~clk100hz;

  logic          variableClk = 1'b0;
  logic          run = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [NW-1:0] wr_note = '0;
  logic          wr_active = 1'b0;
  logic [NW-1:0] note_out;
  logic          gate;
  logic [AW-1:0] step_idx;
  logic          step_pulse;
  logic [1:0]    state_dbg;

  seq_step_engine #(.NUM_STEPS(N), .NOTE_W(NW), .GATE_TICKS(GT)) dut (
    .clk100hz(clk100hz), .reset(reset), .variableClk(variableClk), .run(run),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_active(wr_active),
    .note_out(note_out), .gate(gate), .step_idx(step_idx), .step_pulse(step_pulse),
    .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk100hz) cyc <= cyc + 1;

  // free-running tempo generator; period 0 hands variableClk to the driver tasks
  int vc_period = 50;
  int gen_cnt   = 0;
  always @(negedge clk100hz) begin
    if (vc_period != 0) begin
      variableClk = (gen_cnt % vc_period) < (vc_period / 2);
      gen_cnt++;
    end
  end

  // reference model: a step fires on the 3rd consecutive high sample of variableClk
  bit          pat_act  [N];
  int          pat_note [N];
  int          hi_run, m_ptr, m_gate_left, m_note, m_idx;
  bit          m_running, m_pulse, m_tick;

  always @(posedge clk100hz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin pat_act[i] = 0; pat_note[i] = 0; end
      hi_run = 0; m_ptr = 0; m_gate_left = 0; m_note = 0; m_idx = 0;
      m_running = 0; m_pulse = 0;
    end else begin
      hi_run = variableClk ? hi_run + 1 : 0;
      m_tick = (hi_run == 3);
      m_pulse = 0;
      if (!m_running) begin
        m_ptr = 0; m_gate_left = 0;
        if (run) m_running = 1;
      end else if (!run) begin
        m_running = 0; m_ptr = 0; m_gate_left = 0;
      end else if (m_tick) begin
        m_idx = m_ptr;
        m_pulse = 1;
        if (pat_act[m_ptr]) begin
          m_note = pat_note[m_ptr];
          m_gate_left = GT;
        end else begin
          m_gate_left = 0;
        end
        m_ptr = (m_ptr + 1) % N;
      end else if (m_gate_left > 0) begin
        m_gate_left--;
      end
      if (wr_en) begin
        pat_act[wr_addr]  = wr_active;
        pat_note[wr_addr] = wr_note;
      end
    end
  end

  // scoreboard compare on every cycle out of reset
  always @(negedge clk100hz) begin
    if (chk_en && !reset) begin
      check("model_note", note_out, m_note);
      check("model_gate", gate, (m_gate_left > 0) ? 1 : 0);
      check("model_idx", step_idx, m_idx);
      check("model_pulse", step_pulse, m_pulse);
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic wait_pulse();
    int k = 0;
    do begin @(negedge clk100hz); k++; end while (!step_pulse && k < 200);
    if (!step_pulse) check("pulse_timeout", 0, 1);
  endtask

  task automatic write_entry(input int a, input int n, input bit act);
    wr_en = 1; wr_addr = AW'(a); wr_note = NW'(n); wr_active = act;
    @(negedge clk100hz);
    wr_en = 0;
  endtask

  // manual tempo pulse: high for 3 samples; optional run drop / write on the tick edge
  task automatic vc_pulse(input bit drop_run, input bit do_wr, input int a, input int n);
    @(negedge clk100hz);
    variableClk = 1;
    @(negedge clk100hz);
    @(negedge clk100hz);
    if (drop_run) run = 0;
    if (do_wr) begin wr_en = 1; wr_addr = AW'(a); wr_note = NW'(n); wr_active = 1; end
    @(negedge clk100hz);
    variableClk = 0;
    wr_en = 0;
  endtask

  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] got_note_q[$];
  logic [AW-1:0] got_idx_q[$];
  int            stamp[$];

  initial begin
    #1 reset = 1;
    repeat (3) @(negedge clk100hz);
    reset = 0;
    chk_en = 1;
    @(negedge clk100hz);
    check("rst_note", note_out, 0);
    check("rst_gate", gate, 0);
    check("rst_idx", step_idx, 0);
    check("rst_pulse", step_pulse, 0);

    // basic sequencing, all steps active with notes 1..8
    for (int i = 0; i < N; i++) write_entry(i, i + 1, 1);
    run = 1;
    for (int k = 0; k < 9; k++) begin
      wait_pulse();
      got_note_q.push_back(note_out);
      got_idx_q.push_back(step_idx);
      stamp.push_back(cyc);
    end
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd1};
    for (int k = 0; k < 9; k++) begin
      check("seq_note", got_note_q[k], exp_q[k]);
      check("seq_idx", got_idx_q[k], k % N);
      if (k > 0) check("seq_interval", stamp[k] - stamp[k-1], 50);
    end
    begin
      int g = 0;
      wait_pulse();
      while (gate && g < 100) begin g++; @(negedge clk100hz); end
      check("gate_len", g, GT);
    end

    // inactive step 2
    run = 0;
    @(negedge clk100hz);
    write_entry(2, 3, 0);
    run = 1;
    for (int k = 0; k < 4; k++) begin
      wait_pulse();
      check("inact_idx", step_idx, k);
      if (k == 2) begin
        check("inact_gate", gate, 0);
        check("inact_note", note_out, 2);
      end
    end

    // legato at tempo period 6
    wait_pulse();
    vc_period = 0; variableClk = 0; run = 0;
    @(negedge clk100hz);
    write_entry(2, 3, 1);
    repeat (3) @(negedge clk100hz);
    gen_cnt = 0; vc_period = 6; run = 1;
    wait_pulse();
    begin
      int low = 0;
      repeat (60) begin @(negedge clk100hz); if (!gate) low++; end
      check("legato_low_cycles", low, 0);
    end

    // stop with a simultaneous tick while gated
    wait_pulse();
    vc_period = 0; variableClk = 0;
    repeat (15) @(negedge clk100hz);
    vc_pulse(0, 0, 0, 0);
    check("pre_stop_gate", gate, 1);
    vc_pulse(1, 0, 0, 0);
    check("stop_gate", gate, 0);
    check("stop_pulse", step_pulse, 0);
    check("stop_state", state_dbg, 0);
    run = 1;
    vc_pulse(0, 0, 0, 0);
    check("restart_idx", step_idx, 0);
    check("restart_note", note_out, 1);
    check("restart_pulse", step_pulse, 1);

    // write to the entry being played on the tick edge
    vc_pulse(0, 1, 1, 9);
    check("rbw_idx", step_idx, 1);
    check("rbw_old_note", note_out, 2);
    repeat (7) vc_pulse(0, 0, 0, 0);
    vc_pulse(0, 0, 0, 0);
    check("rbw_new_idx", step_idx, 1);
    check("rbw_new_note", note_out, 9);

    // asynchronous reset mid-gate
    @(posedge clk100hz);
    #2 reset = 1;
    #1;
    check("arst_gate", gate, 0);
    check("arst_note", note_out, 0);
    check("arst_idx", step_idx, 0);
    check("arst_pulse", step_pulse, 0);
    repeat (2) @(negedge clk100hz);
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      vc_pulse(0, 0, 0, 0);
      check("cleared_pulse", step_pulse, 1);
      check("cleared_gate", gate, 0);
      check("cleared_idx", step_idx, k);
    end

    repeat (3) @(negedge clk100hz);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
